// File: rtl/liteeth_sram_fifo_ctrl.sv
// First-word-fall-through stream FIFO around a 1rw1r SRAM macro (rw0 writes, r0 reads).
// A 2-entry output buffer absorbs the macro's 1-cycle read latency so the source side streams at full rate.
module liteeth_sram_fifo_ctrl #(
    parameter int DATA_WIDTH  = 12,
    parameter int DEPTH       = 128,
    parameter int ADDR_WIDTH  = 7,
    parameter int LEVEL_WIDTH = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   clear,
    input  logic                   sink_valid,
    output logic                   sink_ready,
    input  logic [DATA_WIDTH-1:0]  sink_data,
    output logic                   source_valid,
    input  logic                   source_ready,
    output logic [DATA_WIDTH-1:0]  source_data,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   mem_rw0_ce,
    output logic                   mem_rw0_we,
    output logic [ADDR_WIDTH-1:0]  mem_rw0_addr,
    output logic [DATA_WIDTH-1:0]  mem_rw0_wd,
    output logic                   mem_r0_ce,
    output logic [ADDR_WIDTH-1:0]  mem_r0_addr,
    input  logic [DATA_WIDTH-1:0]  mem_r0_rd
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         mem_count_q, mem_count_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [1:0]            out_count_q, out_count_d;
    logic [DATA_WIDTH-1:0] obuf_q [2];
    logic [DATA_WIDTH-1:0] obuf_d [2];

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] stage_occ;
    logic [1:0] cap_idx;

    always_comb begin
        sink_ready   = (mem_count_q != FULL) & ~sys_rst;
        source_valid = (out_count_q != 2'd0);
        source_data  = obuf_q[0];

        push = sink_valid & sink_ready & ~clear;
        pop  = source_valid & source_ready;

        // Words already issued or buffered; a new read may issue only if it will find a free slot.
        stage_occ = {1'b0, out_count_q} + {2'b00, rd_pending_q};
        issue     = (mem_count_q != '0) & (stage_occ < (3'd2 + {2'b00, pop})) & ~clear;

        mem_rw0_ce   = push;
        mem_rw0_we   = push;
        mem_rw0_addr = wr_ptr_q;
        mem_rw0_wd   = sink_data;
        mem_r0_ce    = issue;
        mem_r0_addr  = rd_ptr_q;

        level = LEVEL_WIDTH'(mem_count_q) + LEVEL_WIDTH'(rd_pending_q) + LEVEL_WIDTH'(out_count_q);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(push);
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(issue);
        mem_count_d  = mem_count_q + CW'(push) - CW'(issue);
        rd_pending_d = issue;
        out_count_d  = out_count_q + 2'(rd_pending_q) - 2'(pop);
        cap_idx      = out_count_q - {1'b0, pop};
        obuf_d[0]    = obuf_q[0];
        obuf_d[1]    = obuf_q[1];

        // Pop shifts first, then the returning read lands behind whatever remains.
        if (pop) begin
            obuf_d[0] = obuf_q[1];
        end
        if (rd_pending_q) begin
            obuf_d[cap_idx[0]] = mem_r0_rd;
        end

        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            mem_count_d  = '0;
            rd_pending_d = 1'b0;
            out_count_d  = 2'd0;
            obuf_d[0]    = '0;
            obuf_d[1]    = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            rd_pending_q <= 1'b0;
            out_count_q  <= 2'd0;
            obuf_q[0]    <= '0;
            obuf_q[1]    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_count_q  <= mem_count_d;
            rd_pending_q <= rd_pending_d;
            out_count_q  <= out_count_d;
            obuf_q[0]    <= obuf_d[0];
            obuf_q[1]    <= obuf_d[1];
        end
    end

endmodule
